// File: rtl/drive_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// drive_sequencer_pkg
// Shared definitions for the drive sequencer: main-FSM state codes and the
// sonar distance width.
// ---------------------------------------------------------------------------
package drive_sequencer_pkg;

    localparam int DIST_W = 9;

    typedef enum logic [2:0] {
        PARADO = 3'd0,
        FRENTE = 3'd1,
        RE     = 3'd2,
        GIRA   = 3'd3
    } state_e;

endpackage

// File: rtl/drive_sequencer_meas_sched.sv
// ---------------------------------------------------------------------------
// meas_sched
// Sonar measurement scheduler. While enabled it issues a one-cycle request,
// waits for the answer (or a timeout), and repeats every MEAS_PERIOD cycles
// counted from the previous request.
//
// Ports
//   clk           system clock (rising edge)
//   reset         asynchronous active-low reset
//   i_en          run enable; low idles the scheduler and clears its counters
//   i_dist_valid  one-cycle answer strobe from the sonar
//   i_dist_cm     answered distance in cm
//   o_meas_req    registered one-cycle measurement request
//   o_alerta      registered: last accepted distance was below SAFE_DIST_CM
//   o_obstacle    combinational: an answer below the threshold is accepted now
// ---------------------------------------------------------------------------
module meas_sched
    import drive_sequencer_pkg::*;
#(
    parameter int unsigned MEAS_PERIOD  = 5000000,
    parameter int unsigned MEAS_TIMEOUT = 2000000,
    parameter int unsigned SAFE_DIST_CM = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_en,
    input  logic              i_dist_valid,
    input  logic [DIST_W-1:0] i_dist_cm,
    output logic              o_meas_req,
    output logic              o_alerta,
    output logic              o_obstacle
);

    localparam int PER_W = $clog2(MEAS_PERIOD + 1);
    localparam int TO_W  = $clog2(MEAS_TIMEOUT + 1);
    localparam logic [PER_W-1:0]  PER_DONE = PER_W'(MEAS_PERIOD);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(MEAS_TIMEOUT - 1);
    localparam logic [DIST_W-1:0] SAFE     = DIST_W'(SAFE_DIST_CM);

    logic             r_started;   // first request after enable already sent
    logic             r_waiting;
    logic [PER_W-1:0] r_per_cnt;   // cycles since last request, saturates at PER_DONE
    logic [TO_W-1:0]  r_to_cnt;    // cycles spent waiting
    logic             r_meas_req;
    logic             r_alerta;

    logic w_near, w_accept, w_timeout, w_per_done, w_issue;

    assign w_near     = (i_dist_cm < SAFE);
    assign w_accept   = r_waiting & i_dist_valid;
    // An answer arriving on the last waiting cycle still wins over the timeout.
    assign w_timeout  = r_waiting & ~i_dist_valid & (r_to_cnt == TO_LAST);
    assign w_per_done = (r_per_cnt == PER_DONE);
    // Requests are only issued outside a wait, so an answer that coincides
    // with period expiry is consumed first and the request follows next cycle.
    assign w_issue    = i_en & ~r_waiting & (~r_started | w_per_done);

    assign o_obstacle = w_accept & w_near;
    assign o_meas_req = r_meas_req;
    assign o_alerta   = r_alerta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_started  <= 1'b0;
            r_waiting  <= 1'b0;
            r_per_cnt  <= '0;
            r_to_cnt   <= '0;
            r_meas_req <= 1'b0;
            r_alerta   <= 1'b0;
        end else if (!i_en) begin
            r_started  <= 1'b0;
            r_waiting  <= 1'b0;
            r_per_cnt  <= '0;
            r_to_cnt   <= '0;
            r_meas_req <= 1'b0;
        end else begin
            r_meas_req <= w_issue;
            if (w_issue) begin
                r_started <= 1'b1;
                r_waiting <= 1'b1;
                r_per_cnt <= PER_W'(1);
                r_to_cnt  <= '0;
            end else begin
                if (!w_per_done)
                    r_per_cnt <= r_per_cnt + PER_W'(1);
                if (w_accept) begin
                    r_waiting <= 1'b0;
                    r_alerta  <= w_near;
                end else if (w_timeout) begin
                    r_waiting <= 1'b0;
                    r_alerta  <= 1'b0;
                end else if (r_waiting) begin
                    r_to_cnt  <= r_to_cnt + TO_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/drive_sequencer.sv
// ---------------------------------------------------------------------------
// drive_sequencer
// Obstacle-avoiding drive sequencer: drives forward, and on a near sonar
// reading reverses for REV_CYCLES then turns for TURN_CYCLES before resuming.
//
// Optional feature: define DRIVE_SEQ_ALT_TURN_EN to alternate the turn
// direction on each reverse->turn transition (first turn right). Without it
// every turn is to the right and esquerda is tied low.
//
// Ports
//   clk                 system clock (rising edge)
//   reset               asynchronous active-low reset
//   ligar               run enable; low forces PARADO
//   dist_valid/dist_cm  sonar answer strobe and distance (cm)
//   meas_req            one-cycle measurement request to the sonar
//   frente/tras/direita/esquerda  registered, mutually exclusive motor commands
//   alerta_proximidade  last valid distance below SAFE_DIST_CM
//   db_estado           current state code
// ---------------------------------------------------------------------------
module drive_sequencer
    import drive_sequencer_pkg::*;
#(
    parameter int unsigned MEAS_PERIOD  = 5000000,
    parameter int unsigned MEAS_TIMEOUT = 2000000,
    parameter int unsigned SAFE_DIST_CM = 20,
    parameter int unsigned REV_CYCLES   = 25000000,
    parameter int unsigned TURN_CYCLES  = 20000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ligar,
    input  logic              dist_valid,
    input  logic [DIST_W-1:0] dist_cm,
    output logic              meas_req,
    output logic              frente,
    output logic              tras,
    output logic              direita,
    output logic              esquerda,
    output logic              alerta_proximidade,
    output logic [2:0]        db_estado
);

    localparam int unsigned PH_MAX = (REV_CYCLES > TURN_CYCLES) ? REV_CYCLES : TURN_CYCLES;
    localparam int PH_W = $clog2(PH_MAX + 1);
    localparam logic [PH_W-1:0] PH_SAT    = PH_W'(PH_MAX);
    localparam logic [PH_W-1:0] REV_LAST  = PH_W'(REV_CYCLES - 1);
    localparam logic [PH_W-1:0] TURN_LAST = PH_W'(TURN_CYCLES - 1);

    state_e          r_state;
    logic [PH_W-1:0] r_cnt;
    logic            r_frente, r_tras, r_direita;
`ifdef DRIVE_SEQ_ALT_TURN_EN
    logic            r_esquerda;
    logic            r_turn_left;   // direction of the next turn
`endif

    logic            w_sched_en, w_obstacle;
    logic [PH_W-1:0] w_cnt_inc;

    // Scheduler runs only once the FSM has left PARADO and ligar is still high,
    // so the first request lands one cycle after entering FRENTE.
    assign w_sched_en = ligar & (r_state != PARADO);
    assign w_cnt_inc  = (r_cnt == PH_SAT) ? r_cnt : r_cnt + PH_W'(1);

    meas_sched #(
        .MEAS_PERIOD  (MEAS_PERIOD),
        .MEAS_TIMEOUT (MEAS_TIMEOUT),
        .SAFE_DIST_CM (SAFE_DIST_CM)
    ) u_meas_sched (
        .clk          (clk),
        .reset        (reset),
        .i_en         (w_sched_en),
        .i_dist_valid (dist_valid),
        .i_dist_cm    (dist_cm),
        .o_meas_req   (meas_req),
        .o_alerta     (alerta_proximidade),
        .o_obstacle   (w_obstacle)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= PARADO;
            r_cnt      <= '0;
            r_frente   <= 1'b0;
            r_tras     <= 1'b0;
            r_direita  <= 1'b0;
`ifdef DRIVE_SEQ_ALT_TURN_EN
            r_esquerda  <= 1'b0;
            r_turn_left <= 1'b0;
`endif
        end else if (!ligar) begin
            r_state    <= PARADO;
            r_cnt      <= '0;
            r_frente   <= 1'b0;
            r_tras     <= 1'b0;
            r_direita  <= 1'b0;
`ifdef DRIVE_SEQ_ALT_TURN_EN
            r_esquerda <= 1'b0;
`endif
        end else begin
            case (r_state)
                PARADO: begin
                    r_state  <= FRENTE;
                    r_cnt    <= '0;
                    r_frente <= 1'b1;
                end
                FRENTE: begin
                    if (w_obstacle) begin
                        r_state  <= RE;
                        r_cnt    <= '0;
                        r_frente <= 1'b0;
                        r_tras   <= 1'b1;
                    end
                end
                RE: begin
                    if (r_cnt == REV_LAST) begin
                        r_state <= GIRA;
                        r_cnt   <= '0;
                        r_tras  <= 1'b0;
`ifdef DRIVE_SEQ_ALT_TURN_EN
                        r_direita   <= ~r_turn_left;
                        r_esquerda  <= r_turn_left;
                        r_turn_left <= ~r_turn_left;
`else
                        r_direita <= 1'b1;
`endif
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                GIRA: begin
                    if (r_cnt == TURN_LAST) begin
                        r_state   <= FRENTE;
                        r_cnt     <= '0;
                        r_direita <= 1'b0;
`ifdef DRIVE_SEQ_ALT_TURN_EN
                        r_esquerda <= 1'b0;
`endif
                        r_frente  <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state   <= PARADO;
                    r_cnt     <= '0;
                    r_frente  <= 1'b0;
                    r_tras    <= 1'b0;
                    r_direita <= 1'b0;
`ifdef DRIVE_SEQ_ALT_TURN_EN
                    r_esquerda <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign frente    = r_frente;
    assign tras      = r_tras;
    assign direita   = r_direita;
`ifdef DRIVE_SEQ_ALT_TURN_EN
    assign esquerda  = r_esquerda;
`else
    assign esquerda  = 1'b0;
`endif
    assign db_estado = r_state;

endmodule

// File: tb/tb_drive_sequencer.sv
module tb_drive_sequencer;

    localparam int MP = 100, MT = 30, SD = 20, RC = 50, TC = 40;
`ifdef DRIVE_SEQ_ALT_TURN_EN
    localparam bit ALT = 1'b1;
`else
    localparam bit ALT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, ligar, dist_valid;
    logic [8:0] dist_cm;
    logic       meas_req, frente, tras, direita, esquerda, alerta_proximidade;
    logic [2:0] db_estado;

    drive_sequencer #(
        .MEAS_PERIOD(MP), .MEAS_TIMEOUT(MT), .SAFE_DIST_CM(SD),
        .REV_CYCLES(RC), .TURN_CYCLES(TC)
    ) dut (
        .clk(clk), .reset(reset), .ligar(ligar), .dist_valid(dist_valid),
        .dist_cm(dist_cm), .meas_req(meas_req), .frente(frente), .tras(tras),
        .direita(direita), .esquerda(esquerda),
        .alerta_proximidade(alerta_proximidade), .db_estado(db_estado)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, now = 0;

    // Reference model: time-stamp based view of the behaviour.
    // mode: 0 stopped, 1 forward, 2 reverse, 3 turn
    int m_mode = 0, m_t_enter = 0, m_last_req = 0, m_wait_start = 0, m_turns = 0;
    bit m_started = 0, m_waiting = 0, m_req = 0, m_alert = 0, m_left = 0;

    // Sonar responder
    bit ans_en = 1'b1;
    int ans_dist = 40, pend_at = -1, stray_pct = 0, dmin = 1, dmax = 8;
    int last_req_t = 0;

    task automatic model_reset();
        m_mode = 0; m_turns = 0; m_started = 0; m_waiting = 0;
        m_req = 0; m_alert = 0; m_left = 0; pend_at = -1;
    endtask

    task automatic step();
        bit obst;
        @(posedge clk);
        now++;
        obst = 1'b0;
        if (!(ligar && m_mode != 0)) begin
            m_started = 0; m_waiting = 0; m_req = 0;
        end else if (!m_waiting && (!m_started || now - m_last_req >= MP)) begin
            m_req = 1; m_started = 1; m_last_req = now; m_waiting = 1; m_wait_start = now;
        end else begin
            m_req = 0;
            if (m_waiting && dist_valid) begin
                m_waiting = 0; m_alert = (dist_cm < SD); obst = m_alert;
            end else if (m_waiting && now - m_wait_start >= MT) begin
                m_waiting = 0; m_alert = 0;
            end
        end
        if (!ligar) m_mode = 0;
        else case (m_mode)
            0: m_mode = 1;
            1: if (obst) begin m_mode = 2; m_t_enter = now; end
            2: if (now - m_t_enter >= RC) begin
                   m_mode = 3; m_t_enter = now; m_left = ALT && m_turns[0]; m_turns++;
               end
            default: if (now - m_t_enter >= TC) m_mode = 1;
        endcase
        #1;
    endtask

    task automatic cycle();
        bit fire;
        fire = (pend_at == now + 1);
        dist_valid = fire || ($urandom_range(99) < stray_pct);
        dist_cm = fire ? 9'(ans_dist) : 9'($urandom_range(511));
        if (fire) pend_at = -1;
        step();
        if (m_req && ans_en) pend_at = now + $urandom_range(dmax, dmin);
        if (meas_req === 1'b1) last_req_t = now;
    endtask

    function automatic logic [8:0] obs();
        return {meas_req, frente, tras, direita, esquerda, alerta_proximidade, db_estado};
    endfunction

    function automatic logic [8:0] expv();
        return {m_req, m_mode == 1, m_mode == 2, m_mode == 3 && !m_left,
                m_mode == 3 && m_left, m_alert, 3'(m_mode)};
    endfunction

    task automatic test_reset();
        reset = 1'b0; ligar = 1'b0; dist_valid = 1'b0; dist_cm = '0;
        #2;
        checks++;
        if (obs() !== 9'd0) begin errors++; $display("FAIL reset_async got=%b exp=%b", obs(), 9'd0); end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) begin
            cycle();
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL reset_idle t=%0d got=%b exp=%b", now, obs(), expv()); end
        end
    endtask

    task automatic test_startup();
        int t0;
        int q[$];
        ligar = 1'b1; ans_en = 1'b1; ans_dist = 40;
        cycle();
        t0 = now;
        checks++;
        if (db_estado !== 3'd1 || frente !== 1'b1) begin
            errors++; $display("FAIL start_frente state=%0d frente=%b exp state=1 frente=1", db_estado, frente);
        end
        repeat (215) begin
            cycle();
            if (meas_req === 1'b1) q.push_back(now - t0);
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL startup t=%0d got=%b exp=%b", now, obs(), expv()); end
        end
        checks++;
        if (q.size() < 3 || q[0] != 1 || q[1] != 101 || q[2] != 201) begin
            errors++; $display("FAIL req_times got n=%0d first=%0d exp 1,101,201", q.size(), (q.size() > 0) ? q[0] : -1);
        end
    endtask

    task automatic test_obstacle();
        int n_tras = 0, n_dir = 0, n_esq = 0;
        bit seen_re = 0, done = 0;
        ans_dist = 19;
        for (int i = 0; i < 400 && !done; i++) begin
            cycle();
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL obstacle t=%0d got=%b exp=%b", now, obs(), expv()); end
            if (tras === 1'b1 && !seen_re) begin
                seen_re = 1; ans_dist = 40;
                checks++;
                if (alerta_proximidade !== 1'b1) begin errors++; $display("FAIL obst_alert got=%b exp=1", alerta_proximidade); end
            end
            n_tras += int'(tras === 1'b1);
            n_dir  += int'(direita === 1'b1);
            n_esq  += int'(esquerda === 1'b1);
            if (seen_re && frente === 1'b1) done = 1;
        end
        checks++;
        if (!done || n_tras != RC || n_dir != TC || n_esq != 0) begin
            errors++; $display("FAIL obst_seq done=%0d tras=%0d dir=%0d esq=%0d exp 1/%0d/%0d/0", done, n_tras, n_dir, n_esq, RC, TC);
        end
    endtask

    task automatic test_threshold();
        int not_fwd = 0;
        ans_dist = SD;
        repeat (150) begin
            cycle();
            not_fwd += int'(frente !== 1'b1);
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL threshold t=%0d got=%b exp=%b", now, obs(), expv()); end
        end
        checks++;
        if (not_fwd != 0 || alerta_proximidade !== 1'b0) begin
            errors++; $display("FAIL thresh_clear not_fwd=%0d alert=%b exp 0/0", not_fwd, alerta_proximidade);
        end
    endtask

    task automatic test_ligar_off();
        int n_req = 0, i = 0;
        ans_dist = 19;
        while (tras !== 1'b1 && i < 300) begin
            cycle(); i++;
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL off_pre t=%0d got=%b exp=%b", now, obs(), expv()); end
        end
        checks++;
        if (tras !== 1'b1) begin errors++; $display("FAIL off_reach_re got tras=%b exp=1", tras); end
        repeat (10) cycle();
        ligar = 1'b0;
        cycle();
        checks++;
        if ({db_estado, frente, tras, direita, esquerda} !== 7'd0) begin
            errors++; $display("FAIL off_stop got=%b exp=0", {db_estado, frente, tras, direita, esquerda});
        end
        repeat (150) begin
            cycle();
            n_req += int'(meas_req === 1'b1);
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL off_idle t=%0d got=%b exp=%b", now, obs(), expv()); end
        end
        checks++;
        if (n_req != 0) begin errors++; $display("FAIL off_no_req got=%0d exp=0", n_req); end
        ans_en = 1'b0; pend_at = -1; ligar = 1'b1;
        cycle();
        checks++;
        if (db_estado !== 3'd1 || frente !== 1'b1) begin errors++; $display("FAIL off_restart state=%0d exp=1", db_estado); end
        cycle();
        checks++;
        if (meas_req !== 1'b1) begin errors++; $display("FAIL off_restart_req got=%b exp=1", meas_req); end
    endtask

    task automatic test_timeout();
        int q[$];
        int fall_t = -1, req0;
        bit prev_a;
        req0 = last_req_t;
        q.push_back(last_req_t);
        prev_a = alerta_proximidade;
        repeat (260) begin
            cycle();
            if (meas_req === 1'b1) q.push_back(now);
            if (prev_a === 1'b1 && alerta_proximidade === 1'b0 && fall_t < 0) fall_t = now;
            prev_a = alerta_proximidade;
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL timeout t=%0d got=%b exp=%b", now, obs(), expv()); end
        end
        checks++;
        if (fall_t - req0 != MT) begin errors++; $display("FAIL timeout_clear got=%0d exp=%0d", fall_t - req0, MT); end
        checks++;
        if (q.size() < 3) begin errors++; $display("FAIL timeout_reqs got=%0d exp>=3", q.size()); end
        for (int k = 1; k < q.size(); k++) begin
            checks++;
            if (q[k] - q[k-1] != MP) begin errors++; $display("FAIL timeout_period got=%0d exp=%0d", q[k] - q[k-1], MP); end
        end
        checks++;
        if (db_estado !== 3'd1) begin errors++; $display("FAIL timeout_state got=%0d exp=1", db_estado); end
    endtask

    task automatic test_reset_midrun();
        ans_en = 1'b1; ans_dist = 19;
        repeat (60) cycle();
        #2 reset = 1'b0;
        #1;
        checks++;
        if (obs() !== 9'd0) begin errors++; $display("FAIL reset_mid got=%b exp=0", obs()); end
        model_reset();
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_alt_turn();
        int n_dir[2], n_esq[2];
        int idx = -1;
        bit prev_g = 0, g;
        n_dir = '{0, 0}; n_esq = '{0, 0};
        ans_en = 1'b1; ans_dist = 19;
        for (int i = 0; i < 900 && !(idx == 1 && frente === 1'b1); i++) begin
            cycle();
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL alt t=%0d got=%b exp=%b", now, obs(), expv()); end
            g = (direita === 1'b1) || (esquerda === 1'b1);
            if (g && !prev_g) idx++;
            prev_g = g;
            if (idx >= 0 && idx < 2) begin
                n_dir[idx] += int'(direita === 1'b1);
                n_esq[idx] += int'(esquerda === 1'b1);
            end
        end
        checks++;
        if (n_dir[0] != TC || n_esq[0] != 0) begin
            errors++; $display("FAIL alt_turn1 dir=%0d esq=%0d exp %0d/0", n_dir[0], n_esq[0], TC);
        end
        checks++;
        if (n_dir[1] != (ALT ? 0 : TC) || n_esq[1] != (ALT ? TC : 0)) begin
            errors++; $display("FAIL alt_turn2 dir=%0d esq=%0d exp %0d/%0d", n_dir[1], n_esq[1], ALT ? 0 : TC, ALT ? TC : 0);
        end
    endtask

    task automatic test_random();
        stray_pct = 3; dmin = 1; dmax = 35;
        repeat (3000) begin
            ans_en = ($urandom_range(99) < 80);
            ans_dist = $urandom_range(40);
            if ($urandom_range(299) == 0) ligar = ~ligar;
            cycle();
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL random t=%0d got=%b exp=%b", now, obs(), expv()); end
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_obstacle();
        test_threshold();
        test_ligar_off();
        test_timeout();
        test_reset_midrun();
        test_alt_turn();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
